tdp_bram_be: RTL and testbench
==============================

# tdp_bram_be

Parametrised true-dual-port block RAM with per-port enables, byte-lane write enables, a selectable same-port read-during-write mode and fully defined cross-port collision behaviour. It is the successor to the plain two-port inference test design: every collision case that used to read back as 'x now returns a defined value and raises a flag. It serves as the inference and formal-equivalence target for the QLF BRAM mapping, and as a reusable memory in designs that need deterministic dual-port semantics.

## Interface
- ABITS, 10: address width.
- DBITS, 36: data width; must be divisible by BE_WIDTH.
- DEPTH, 1024: word count; DEPTH ≤ 2**ABITS.
- BE_WIDTH, 4: byte lanes per word; lane width LW = DBITS/BE_WIDTH.
- RDW_MODE, RDW_READ_FIRST: same-port read-during-write mode (package enum).

- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en_a  in  1  port A enable; low means no read and no write.
- we_a  in  BE_WIDTH  port A lane write enables.
- a_a  in  ABITS  port A address.
- wd_a  in  DBITS  port A write data.
- rd_a  out  DBITS  port A read data.
- en_b, we_b, a_b, wd_b, rd_b: same as port A, for port B.
- coll_ww  out  1  pulse: both ports wrote overlapping lanes at the same address.
- coll_rw  out  1  pulse: one port read an address the other port wrote.

## Operation
- Port active when en_x=1 and rst=0. Active ports read every cycle and write lane i when we_x[i]=1.
- Addresses ≥ DEPTH: write ignored; read returns 0.
- Same-port read-during-write, selected by RDW_MODE:
  - READ_FIRST: rd_x = old word.
  - WRITE_FIRST: rd_x = old word with the written lanes replaced by wd_x.
  - NO_CHANGE: rd_x holds its previous value whenever any bit of we_x is set.
- Cross-port, same address, same cycle:
  - Write/write: on overlapping lanes port A wins; on non-overlapping lanes each port writes its own lanes. coll_ww=1.
  - Read/write: the reading port sees the old word (cross-port is always read-first). coll_rw=1.
  - If both ports write, each port applies its own RDW_MODE to its own read; old data still comes from the pre-cycle contents.
- Port disabled (en_x=0): rd_x holds its value and the port takes no part in collision detection.
- rst: rd_a, rd_b, coll_ww and coll_rw all go to 0. Writes are suppressed during rst; memory contents are not cleared.

## Timing
- Read latency is 1 cycle, or 2 with TDP_BRAM_OREG_EN. Write is visible to a read issued on the next cycle.
- coll_ww and coll_rw are registered and align with the rd outputs of the colliding access (1 or 2 cycles). They are one-cycle pulses.
- Reset mid-operation: the outputs are 0 on the cycle after rst is sampled high. A write presented in the same cycle as rst is dropped. With OREG, both pipeline stages clear.
- No handshake: a port accepts a new access every cycle.

## Configuration
- TDP_BRAM_OREG_EN defined: adds an output register stage on each port.
  - rd_a, rd_b, coll_ww and coll_rw are delayed one extra cycle.
  - The output register updates only when the port was enabled in the previous cycle; otherwise it holds.
  - The stage resets to 0.
- TDP_BRAM_OREG_EN undefined: single-stage read path, 1-cycle latency.

## Structure
- Package tdp_bram_pkg holds:
  - typedef enum rdw_mode_e {RDW_READ_FIRST, RDW_WRITE_FIRST, RDW_NO_CHANGE};
  - a function for lane merging (old word, new word, lane mask, LW).
- Sub-module tdp_bram_rdport, instantiated once per port. It takes the old word, this port's write, en and rst, and produces the registered read word, including the RDW mux and the optional OREG stage.
- Top level holds:
  - the memory array with `syn_ramstyle = "block_ram"`;
  - the A-over-B lane priority logic;
  - the collision comparators.

## Test plan
Configuration for all scenarios: DBITS=16, BE_WIDTH=2, ABITS=4, no OREG unless stated.
- Reset: write 0xBEEF at address 3, assert rst for 1 cycle, read address 3 → rd_a=0 during reset, then 0xBEEF; coll_* stay 0.
- Byte enables: mem[5]=0x1234; A writes 0xABCD with we_a=2'b01 → reading address 5 returns 0x12CD.
- RDW modes: mem[2]=0x1111; A writes 0x2222 at address 2 → READ_FIRST rd_a=0x1111; WRITE_FIRST rd_a=0x2222; NO_CHANGE rd_a=previous rd_a.
- Write/write collision: A writes 0xAAAA with we=11 and B writes 0xBBBB with we=11, both at address 7 → mem[7]=0xAAAA, coll_ww=1 for one cycle. Repeat with we_a=01, we_b=10 → mem[7]=0xBBAA.
- Read/write collision: mem[9]=0x0F0F; B reads address 9 while A writes 0x5555 there → rd_b=0x0F0F, coll_rw=1; the next read of address 9 returns 0x5555.
- OREG build: repeat the byte-enable scenario → the result appears 2 cycles after the read address. Pulsing en_a low holds rd_a.

Source files
------------

// File: rtl/tdp_bram_pkg.sv
// tdp_bram_pkg -- shared types and helpers for the tdp_bram_be memory.
//
// Contents:
//   rdw_mode_e     same-port read-during-write behaviour selector
//   TDP_MAX_DBITS  widest word the lane_merge helper handles
//   TDP_MAX_LANES  most byte lanes the lane_merge helper handles
//   lane_merge()   replace the lanes of an old word selected by a lane mask
//                  with the matching lanes of a new word
package tdp_bram_pkg;

  typedef enum logic [1:0] {
    RDW_READ_FIRST  = 2'd0,
    RDW_WRITE_FIRST = 2'd1,
    RDW_NO_CHANGE   = 2'd2
  } rdw_mode_e;

  localparam int TDP_MAX_DBITS = 256;
  localparam int TDP_MAX_LANES = 64;

  // Callers zero-extend their words/masks to the maximum widths and truncate
  // the result back. lw is a constant at every call site, so the division
  // folds away in synthesis and this reduces to a per-bit 2:1 mux.
  function automatic logic [TDP_MAX_DBITS-1:0] lane_merge(
    input logic [TDP_MAX_DBITS-1:0] old_word,
    input logic [TDP_MAX_DBITS-1:0] new_word,
    input logic [TDP_MAX_LANES-1:0] lane_mask,
    input int                       lw
  );
    logic [TDP_MAX_DBITS-1:0] merged;
    logic [5:0]               lane;
    merged = old_word;
    for (int i = 0; i < TDP_MAX_DBITS; i++) begin
      if ((i / lw) < TDP_MAX_LANES) begin
        lane = 6'(i / lw);
        if (lane_mask[lane]) merged[i] = new_word[i];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/tdp_bram_be_rdport.sv
// tdp_bram_rdport -- registered read path for one port of tdp_bram_be.
//
// Applies the same-port read-during-write mode to the pre-cycle memory word
// and registers the result. With TDP_BRAM_OREG_EN defined a second register
// stage is added; it loads only when the port was enabled on the previous
// cycle, otherwise it holds.
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset, clears both stages
//   i_en   in   port enable; low holds the read register
//   i_we   in   [BE_WIDTH] lanes this port writes this cycle (already gated
//               by rst and address range)
//   i_wd   in   [DBITS] this port's write data
//   i_old  in   [DBITS] word at this port's address before this cycle's writes
//               (0 for out-of-range addresses)
//   o_rd   out  [DBITS] registered read data
module tdp_bram_rdport
  import tdp_bram_pkg::*;
#(
  parameter int        DBITS    = 36,
  parameter int        BE_WIDTH = 4,
  parameter rdw_mode_e RDW_MODE = RDW_READ_FIRST
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_en,
  input  logic [BE_WIDTH-1:0] i_we,
  input  logic [DBITS-1:0]    i_wd,
  input  logic [DBITS-1:0]    i_old,
  output logic [DBITS-1:0]    o_rd
);

  localparam int LW = DBITS / BE_WIDTH;

  logic [DBITS-1:0] w_merged;
  logic [DBITS-1:0] w_next;
  logic             w_hold;
  logic [DBITS-1:0] r_rd1;

  always_comb begin
    w_merged = DBITS'(lane_merge(TDP_MAX_DBITS'(i_old), TDP_MAX_DBITS'(i_wd),
                                 TDP_MAX_LANES'(i_we), LW));
    w_next   = i_old;
    w_hold   = 1'b0;
    case (RDW_MODE)
      RDW_WRITE_FIRST: w_next = w_merged;
      RDW_NO_CHANGE:   w_hold = |i_we;
      default:         w_next = i_old;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd1 <= '0;
    end else if (i_en && !w_hold) begin
      r_rd1 <= w_next;
    end
  end

`ifdef TDP_BRAM_OREG_EN
  logic             r_en_d;
  logic [DBITS-1:0] r_rd2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_en_d <= 1'b0;
      r_rd2  <= '0;
    end else begin
      r_en_d <= i_en;
      if (r_en_d) r_rd2 <= r_rd1;
    end
  end

  assign o_rd = r_rd2;
`else
  assign o_rd = r_rd1;
`endif

endmodule

// File: rtl/tdp_bram_be.sv
// tdp_bram_be -- true-dual-port block RAM with byte-lane write enables,
// selectable same-port read-during-write mode and defined cross-port
// collision behaviour.
//
// Optional build macro: TDP_BRAM_OREG_EN adds an output register stage per
// port; read data and collision flags then arrive 2 cycles after the access
// instead of 1.
//
// Ports (port B identical to port A):
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset; clears outputs, drops writes,
//                 leaves memory contents alone
//   en_a     in   port A enable (no read, no write when low; rd_a holds)
//   we_a     in   [BE_WIDTH] port A lane write enables
//   a_a      in   [ABITS] port A address; >= DEPTH ignores writes, reads 0
//   wd_a     in   [DBITS] port A write data
//   rd_a     out  [DBITS] port A read data
//   coll_ww  out  both ports wrote overlapping lanes of one address (pulse)
//   coll_rw  out  exactly one port wrote an address the other port read (pulse)
//
// No handshake: each enabled port accepts one access every cycle.
module tdp_bram_be
  import tdp_bram_pkg::*;
#(
  parameter int        ABITS    = 10,
  parameter int        DBITS    = 36,
  parameter int        DEPTH    = 1024,
  parameter int        BE_WIDTH = 4,
  parameter rdw_mode_e RDW_MODE = RDW_READ_FIRST
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en_a,
  input  logic [BE_WIDTH-1:0] we_a,
  input  logic [ABITS-1:0]    a_a,
  input  logic [DBITS-1:0]    wd_a,
  output logic [DBITS-1:0]    rd_a,
  input  logic                en_b,
  input  logic [BE_WIDTH-1:0] we_b,
  input  logic [ABITS-1:0]    a_b,
  input  logic [DBITS-1:0]    wd_b,
  output logic [DBITS-1:0]    rd_b,
  output logic                coll_ww,
  output logic                coll_rw
);

  localparam int               LW      = DBITS / BE_WIDTH;
  localparam logic [ABITS:0]   DEPTH_L = (ABITS + 1)'(DEPTH);

  (* syn_ramstyle = "block_ram" *) logic [DBITS-1:0] r_mem [DEPTH];

  logic                w_act_a, w_act_b;
  logic                w_inr_a, w_inr_b;
  logic [BE_WIDTH-1:0] w_we_a, w_we_b, w_we_b_mem;
  logic                w_same;
  logic [DBITS-1:0]    w_old_a, w_old_b;
  logic                w_ww, w_rw;
  logic                r_ww1, r_rw1;

  always_comb begin
    w_act_a = en_a & ~rst;
    w_act_b = en_b & ~rst;
    w_inr_a = {1'b0, a_a} < DEPTH_L;
    w_inr_b = {1'b0, a_b} < DEPTH_L;
    // Lanes each port really writes; nothing lands out of range or in reset.
    w_we_a  = (w_act_a && w_inr_a) ? we_a : '0;
    w_we_b  = (w_act_b && w_inr_b) ? we_b : '0;
    // Collisions only concern two active ports touching one real word.
    w_same  = w_act_a & w_act_b & w_inr_a & (a_a == a_b);
    // Port A wins overlapping lanes; B keeps only the lanes A leaves alone.
    w_we_b_mem = w_we_b & ~(w_same ? w_we_a : '0);
    w_old_a = w_inr_a ? r_mem[a_a] : '0;
    w_old_b = w_inr_b ? r_mem[a_b] : '0;
    w_ww    = w_same & (|(w_we_a & w_we_b));
    // Exactly one side writing means the other side is a pure read of the
    // same word; when both write, each read follows its own RDW mode.
    w_rw    = w_same & ((|w_we_a) ^ (|w_we_b));
  end

  // Lane writes from the two ports never target the same bits (B is masked
  // above), so both can be issued in one block without ordering concerns.
  always_ff @(posedge clk) begin
    for (int l = 0; l < BE_WIDTH; l++) begin
      if (w_we_a[l])     r_mem[a_a][l*LW +: LW] <= wd_a[l*LW +: LW];
      if (w_we_b_mem[l]) r_mem[a_b][l*LW +: LW] <= wd_b[l*LW +: LW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ww1 <= 1'b0;
      r_rw1 <= 1'b0;
    end else begin
      r_ww1 <= w_ww;
      r_rw1 <= w_rw;
    end
  end

`ifdef TDP_BRAM_OREG_EN
  logic r_ww2, r_rw2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ww2 <= 1'b0;
      r_rw2 <= 1'b0;
    end else begin
      r_ww2 <= r_ww1;
      r_rw2 <= r_rw1;
    end
  end

  assign coll_ww = r_ww2;
  assign coll_rw = r_rw2;
`else
  assign coll_ww = r_ww1;
  assign coll_rw = r_rw1;
`endif

  tdp_bram_rdport #(
    .DBITS   (DBITS),
    .BE_WIDTH(BE_WIDTH),
    .RDW_MODE(RDW_MODE)
  ) u_rdport_a (
    .clk  (clk),
    .rst  (rst),
    .i_en (en_a),
    .i_we (w_we_a),
    .i_wd (wd_a),
    .i_old(w_old_a),
    .o_rd (rd_a)
  );

  tdp_bram_rdport #(
    .DBITS   (DBITS),
    .BE_WIDTH(BE_WIDTH),
    .RDW_MODE(RDW_MODE)
  ) u_rdport_b (
    .clk  (clk),
    .rst  (rst),
    .i_en (en_b),
    .i_we (w_we_b),
    .i_wd (wd_b),
    .i_old(w_old_b),
    .o_rd (rd_b)
  );

endmodule

// File: tb/tb_tdp_bram_be.sv
// tb_tdp_bram_be -- bench for tdp_bram_be (DBITS=16, BE_WIDTH=2, ABITS=4,
// DEPTH=12 so the out-of-range path is reachable).
// Three instances share the same stimulus: READ_FIRST (main), WRITE_FIRST
// and NO_CHANGE, so every RDW mode is seen on port A.
module tb_tdp_bram_be;
  import tdp_bram_pkg::*;

`ifdef TDP_BRAM_OREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int PERIOD = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #(PERIOD/2) clk = ~clk;

  logic        rst  = 1'b1;
  logic        en_a = 1'b0, en_b = 1'b0;
  logic [1:0]  we_a = '0, we_b = '0;
  logic [3:0]  a_a  = '0, a_b  = '0;
  logic [15:0] wd_a = '0, wd_b = '0;

  logic [15:0] rd_a_rf, rd_b_rf, rd_a_wf, rd_b_wf, rd_a_nc, rd_b_nc;
  logic        ww_rf, rw_rf, ww_wf, rw_wf, ww_nc, rw_nc;

  tdp_bram_be #(.ABITS(4), .DBITS(16), .DEPTH(12), .BE_WIDTH(2),
                .RDW_MODE(RDW_READ_FIRST)) dut (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .a_a(a_a), .wd_a(wd_a), .rd_a(rd_a_rf),
    .en_b(en_b), .we_b(we_b), .a_b(a_b), .wd_b(wd_b), .rd_b(rd_b_rf),
    .coll_ww(ww_rf), .coll_rw(rw_rf));

  tdp_bram_be #(.ABITS(4), .DBITS(16), .DEPTH(12), .BE_WIDTH(2),
                .RDW_MODE(RDW_WRITE_FIRST)) dut_wf (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .a_a(a_a), .wd_a(wd_a), .rd_a(rd_a_wf),
    .en_b(en_b), .we_b(we_b), .a_b(a_b), .wd_b(wd_b), .rd_b(rd_b_wf),
    .coll_ww(ww_wf), .coll_rw(rw_wf));

  tdp_bram_be #(.ABITS(4), .DBITS(16), .DEPTH(12), .BE_WIDTH(2),
                .RDW_MODE(RDW_NO_CHANGE)) dut_nc (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .a_a(a_a), .wd_a(wd_a), .rd_a(rd_a_nc),
    .en_b(en_b), .we_b(we_b), .a_b(a_b), .wd_b(wd_b), .rd_b(rd_b_nc),
    .coll_ww(ww_nc), .coll_rw(rw_nc));

  // ---------------- scoreboard ----------------
  // care bits: [0] rd_a (READ_FIRST), [1] rd_b, [2] rd_a WRITE_FIRST,
  //            [3] rd_a NO_CHANGE, [4] coll_ww/coll_rw
  typedef struct {
    time         due;
    string       name;
    logic [4:0]  care;
    logic [15:0] a_rf, b_rf, a_wf, a_nc;
    logic        ww, rw;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(
    input string name, input logic r,
    input logic ea, input logic [1:0] wa, input logic [3:0] aa, input logic [15:0] da,
    input logic eb, input logic [1:0] wb, input logic [3:0] ab, input logic [15:0] db,
    input logic [4:0] care,
    input logic [15:0] xa, input logic [15:0] xb, input logic [15:0] xwf, input logic [15:0] xnc,
    input logic xww, input logic xrw);
    exp_t e;
    @(negedge clk);
    rst = r;
    en_a = ea; we_a = wa; a_a = aa; wd_a = da;
    en_b = eb; we_b = wb; a_b = ab; wd_b = db;
    e.due  = $time + LAT * PERIOD;
    e.name = name;
    e.care = care;
    e.a_rf = xa; e.b_rf = xb; e.a_wf = xwf; e.a_nc = xnc;
    e.ww   = xww; e.rw = xrw;
    exp_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  exp_t m;
  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].due <= $time) begin
        m = exp_q.pop_front();
        if (m.care[0]) chk({m.name, ".rd_a"},    rd_a_rf, m.a_rf);
        if (m.care[1]) chk({m.name, ".rd_b"},    rd_b_rf, m.b_rf);
        if (m.care[2]) chk({m.name, ".rd_a_wf"}, rd_a_wf, m.a_wf);
        if (m.care[3]) chk({m.name, ".rd_a_nc"}, rd_a_nc, m.a_nc);
        if (m.care[4]) begin
          chk({m.name, ".coll_ww"}, {15'd0, ww_rf}, {15'd0, m.ww});
          chk({m.name, ".coll_rw"}, {15'd0, rw_rf}, {15'd0, m.rw});
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  //    name         rst ea we   aa     wd        eb we   ab     wd        care      rd_a      rd_b      wf        nc        ww rw
  initial begin
    step("reset",     1, 0, 2'b00, 4'd0, 16'h0000, 0, 2'b00, 4'd0, 16'h0000, 5'b11111, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    step("wr3",       0, 1, 2'b11, 4'd3, 16'hBEEF, 0, 2'b00, 4'd0, 16'h0000, 5'b11110, 16'h0000, 16'h0000, 16'hBEEF, 16'h0000, 0, 0);
    step("idle",      0, 0, 2'b00, 4'd0, 16'h0000, 0, 2'b00, 4'd0, 16'h0000, 5'b00000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    step("rst_wr3",   1, 1, 2'b11, 4'd3, 16'h0000, 1, 2'b00, 4'd3, 16'h0000, 5'b11111, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    step("rd3",       0, 1, 2'b00, 4'd3, 16'h0000, 0, 2'b00, 4'd0, 16'h0000, 5'b11111, 16'hBEEF, 16'h0000, 16'hBEEF, 16'hBEEF, 0, 0);
    step("wr5",       0, 1, 2'b11, 4'd5, 16'h1234, 0, 2'b00, 4'd0, 16'h0000, 5'b11110, 16'h0000, 16'h0000, 16'h1234, 16'hBEEF, 0, 0);
    step("be5",       0, 1, 2'b01, 4'd5, 16'hABCD, 0, 2'b00, 4'd0, 16'h0000, 5'b11111, 16'h1234, 16'h0000, 16'h12CD, 16'hBEEF, 0, 0);
    step("rd5",       0, 1, 2'b00, 4'd5, 16'h0000, 0, 2'b00, 4'd0, 16'h0000, 5'b11111, 16'h12CD, 16'h0000, 16'h12CD, 16'h12CD, 0, 0);
    step("wr2",       0, 1, 2'b11, 4'd2, 16'h1111, 0, 2'b00, 4'd0, 16'h0000, 5'b11110, 16'h0000, 16'h0000, 16'h1111, 16'h12CD, 0, 0);
    step("rdw2",      0, 1, 2'b11, 4'd2, 16'h2222, 0, 2'b00, 4'd0, 16'h0000, 5'b11111, 16'h1111, 16'h0000, 16'h2222, 16'h12CD, 0, 0);
    step("rd2",       0, 1, 2'b00, 4'd2, 16'h0000, 0, 2'b00, 4'd0, 16'h0000, 5'b11111, 16'h2222, 16'h0000, 16'h2222, 16'h2222, 0, 0);
    step("ww7",       0, 1, 2'b11, 4'd7, 16'hAAAA, 1, 2'b11, 4'd7, 16'hBBBB, 5'b11100, 16'h0000, 16'h0000, 16'hAAAA, 16'h2222, 1, 0);
    step("rd7",       0, 1, 2'b00, 4'd7, 16'h0000, 1, 2'b00, 4'd7, 16'h0000, 5'b11111, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA, 0, 0);
    step("ww7_split", 0, 1, 2'b01, 4'd7, 16'hAAAA, 1, 2'b10, 4'd7, 16'hBBBB, 5'b11111, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA, 0, 0);
    step("rd7_split", 0, 1, 2'b00, 4'd7, 16'h0000, 1, 2'b00, 4'd7, 16'h0000, 5'b11111, 16'hBBAA, 16'hBBAA, 16'hBBAA, 16'hBBAA, 0, 0);
    step("wr9",       0, 1, 2'b11, 4'd9, 16'h0F0F, 0, 2'b00, 4'd0, 16'h0000, 5'b11110, 16'h0000, 16'hBBAA, 16'h0F0F, 16'hBBAA, 0, 0);
    step("rw9",       0, 1, 2'b11, 4'd9, 16'h5555, 1, 2'b00, 4'd9, 16'h0000, 5'b11111, 16'h0F0F, 16'h0F0F, 16'h5555, 16'hBBAA, 0, 1);
    step("hold_a",    0, 0, 2'b00, 4'd9, 16'h0000, 1, 2'b00, 4'd9, 16'h0000, 5'b11111, 16'h0F0F, 16'h5555, 16'h5555, 16'hBBAA, 0, 0);
    step("oor_wr",    0, 1, 2'b11, 4'd13, 16'h7777, 1, 2'b00, 4'd13, 16'h0000, 5'b00011, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    step("oor_rd",    0, 1, 2'b00, 4'd13, 16'h0000, 1, 2'b00, 4'd13, 16'h0000, 5'b01111, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    step("rw4_b",     0, 1, 2'b00, 4'd4, 16'h0000, 1, 2'b11, 4'd4, 16'h4444, 5'b10000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 1);
    step("rd4",       0, 1, 2'b00, 4'd4, 16'h0000, 1, 2'b00, 4'd4, 16'h0000, 5'b11111, 16'h4444, 16'h4444, 16'h4444, 16'h4444, 0, 0);
    step("idle_end",  0, 0, 2'b00, 4'd0, 16'h0000, 0, 2'b00, 4'd0, 16'h0000, 5'b00000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0);

    // Bounded drain: every queued expectation must have been consumed.
    repeat (LAT + 3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
